// File: rtl/id_regread_stage.sv
`default_nettype none
//============================================================================
// Module   : id_regread_stage
// Brief    : Decode-stage 32 x DATA_W register file (2R/1W, X31 = zero)
//            with ID/EX operand pipeline register. Optional macro
//            REGREAD_BYPASS_EN adds MEM/WB write-through bypass and
//            stall refresh of held operands.
// Revision : 1.0 - initial release
//============================================================================
module id_regread_stage #(
    parameter int DATA_W   = 64,
    parameter int ZERO_REG = 31
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [4:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              in_valid,
    input  logic [4:0]        rn_addr,
    input  logic [4:0]        rm_addr,
    input  logic              stall,
    input  logic              flush,
    output logic              ex_valid,
    output logic [4:0]        ex_rn,
    output logic [4:0]        ex_rm,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic              ex_byp1,
    output logic              ex_byp2
);

    localparam logic [4:0] c_zero_addr = 5'(ZERO_REG);

    logic [DATA_W-1:0] r_regs [32];

    logic              r_ex_valid;
    logic [4:0]        r_ex_rn;
    logic [4:0]        r_ex_rm;
    logic [DATA_W-1:0] r_ex_rd1;
    logic [DATA_W-1:0] r_ex_rd2;
    logic              r_ex_byp1;
    logic              r_ex_byp2;

    logic              w_wr_ok;
    logic [DATA_W-1:0] w_arr1;
    logic [DATA_W-1:0] w_arr2;
    logic              w_byp1;
    logic              w_byp2;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;
    logic              w_ref1;
    logic              w_ref2;

    assign w_wr_ok = wr_en && (wr_addr != c_zero_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    assign w_arr1 = (rn_addr == c_zero_addr) ? '0 : r_regs[rn_addr];
    assign w_arr2 = (rm_addr == c_zero_addr) ? '0 : r_regs[rm_addr];

`ifdef REGREAD_BYPASS_EN
    // w_wr_ok already excludes the zero register, so a zero-register read never bypasses
    assign w_byp1 = w_wr_ok && (wr_addr == rn_addr);
    assign w_byp2 = w_wr_ok && (wr_addr == rm_addr);
    assign w_ref1 = w_wr_ok && (wr_addr == r_ex_rn);
    assign w_ref2 = w_wr_ok && (wr_addr == r_ex_rm);
`else
    assign w_byp1 = 1'b0;
    assign w_byp2 = 1'b0;
    assign w_ref1 = 1'b0;
    assign w_ref2 = 1'b0;
`endif

    assign w_rd1 = w_byp1 ? wr_data : w_arr1;
    assign w_rd2 = w_byp2 ? wr_data : w_arr2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid <= 1'b0;
            r_ex_rn    <= '0;
            r_ex_rm    <= '0;
            r_ex_rd1   <= '0;
            r_ex_rd2   <= '0;
            r_ex_byp1  <= 1'b0;
            r_ex_byp2  <= 1'b0;
        end else if (flush) begin
            r_ex_valid <= 1'b0;
            r_ex_rn    <= '0;
            r_ex_rm    <= '0;
            r_ex_rd1   <= '0;
            r_ex_rd2   <= '0;
            r_ex_byp1  <= 1'b0;
            r_ex_byp2  <= 1'b0;
        end else if (stall) begin
            // Held operands pick up a matching writeback so they never go stale
            if (w_ref1) begin
                r_ex_rd1  <= wr_data;
                r_ex_byp1 <= 1'b1;
            end
            if (w_ref2) begin
                r_ex_rd2  <= wr_data;
                r_ex_byp2 <= 1'b1;
            end
        end else begin
            r_ex_valid <= in_valid;
            r_ex_rn    <= rn_addr;
            r_ex_rm    <= rm_addr;
            r_ex_rd1   <= w_rd1;
            r_ex_rd2   <= w_rd2;
            r_ex_byp1  <= w_byp1;
            r_ex_byp2  <= w_byp2;
        end
    end

    assign ex_valid = r_ex_valid;
    assign ex_rn    = r_ex_rn;
    assign ex_rm    = r_ex_rm;
    assign ex_rd1   = r_ex_rd1;
    assign ex_rd2   = r_ex_rd2;
    assign ex_byp1  = r_ex_byp1;
    assign ex_byp2  = r_ex_byp2;

endmodule
`default_nettype wire

// File: tb/tb_id_regread_stage.sv
`default_nettype none
//============================================================================
// Module   : tb_id_regread_stage
// Brief    : Scoreboard bench for id_regread_stage; expected ID/EX state is
//            queued by the driver and compared by an independent monitor.
// Revision : 1.0 - initial release
//============================================================================
module tb_id_regread_stage;

    localparam int DATA_W = 64;
`ifdef REGREAD_BYPASS_EN
    localparam bit c_byp = 1'b1;
`else
    localparam bit c_byp = 1'b0;
`endif

    typedef struct packed {
        logic              v;
        logic [4:0]        rn;
        logic [4:0]        rm;
        logic [DATA_W-1:0] rd1;
        logic [DATA_W-1:0] rd2;
        logic              b1;
        logic              b2;
    } ex_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wr_en;
    logic [4:0]        wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              in_valid;
    logic [4:0]        rn_addr;
    logic [4:0]        rm_addr;
    logic              stall;
    logic              flush;
    logic              ex_valid;
    logic [4:0]        ex_rn;
    logic [4:0]        ex_rm;
    logic [DATA_W-1:0] ex_rd1;
    logic [DATA_W-1:0] ex_rd2;
    logic              ex_byp1;
    logic              ex_byp2;

    int errors = 0;
    int checks = 0;

    ex_t               exp_q[$];
    logic [DATA_W-1:0] m_regs [32];
    ex_t               m_ex;

    id_regread_stage #(.DATA_W(DATA_W), .ZERO_REG(31)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .in_valid(in_valid), .rn_addr(rn_addr), .rm_addr(rm_addr),
        .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_rn(ex_rn), .ex_rm(ex_rm),
        .ex_rd1(ex_rd1), .ex_rd2(ex_rd2),
        .ex_byp1(ex_byp1), .ex_byp2(ex_byp2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Operand as the decode stage should see it this cycle
    task automatic model_read(input logic [4:0] a, input logic we, input logic [4:0] wa,
                              input logic [DATA_W-1:0] wd,
                              output logic [DATA_W-1:0] val, output logic byp);
        if (a == 5'd31) begin
            val = '0; byp = 1'b0;
        end else if (c_byp && we && wa == a) begin
            val = wd; byp = 1'b1;
        end else begin
            val = m_regs[a]; byp = 1'b0;
        end
    endtask

    task automatic model_step(input logic r, input logic we, input logic [4:0] wa,
                              input logic [DATA_W-1:0] wd, input logic iv,
                              input logic [4:0] a1, input logic [4:0] a2,
                              input logic st, input logic fl);
        ex_t n;
        logic [DATA_W-1:0] v1, v2;
        logic b1, b2;
        if (!r) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_ex = '0;
            return;
        end
        model_read(a1, we, wa, wd, v1, b1);
        model_read(a2, we, wa, wd, v2, b2);
        if (fl) begin
            n = '0;
        end else if (st) begin
            n = m_ex;
            if (c_byp && we && wa != 5'd31 && wa == m_ex.rn) begin n.rd1 = wd; n.b1 = 1'b1; end
            if (c_byp && we && wa != 5'd31 && wa == m_ex.rm) begin n.rd2 = wd; n.b2 = 1'b1; end
        end else begin
            n = '{v: iv, rn: a1, rm: a2, rd1: v1, rd2: v2, b1: b1, b2: b2};
        end
        if (we && wa != 5'd31) m_regs[wa] = wd;
        m_ex = n;
    endtask

    task automatic cycle(input logic r, input logic we, input logic [4:0] wa,
                         input logic [DATA_W-1:0] wd, input logic iv,
                         input logic [4:0] a1, input logic [4:0] a2,
                         input logic st, input logic fl);
        @(negedge clk);
        rst_n = r; wr_en = we; wr_addr = wa; wr_data = wd; in_valid = iv;
        rn_addr = a1; rm_addr = a2; stall = st; flush = fl;
        if (!r) begin
            #1;
            chk("async_rst_valid", {63'd0, ex_valid}, '0);
            chk("async_rst_rd1", ex_rd1, '0);
            chk("async_rst_rd2", ex_rd2, '0);
            chk("async_rst_fields", {51'd0, ex_rn, ex_rm, ex_byp1, ex_byp2}, '0);
        end
        model_step(r, we, wa, wd, iv, a1, a2, st, fl);
        exp_q.push_back(m_ex);
    endtask

    // Monitor: every edge produces one ID/EX state to compare
    always @(posedge clk) begin
        ex_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ex_valid", {63'd0, ex_valid}, {63'd0, e.v});
            chk("ex_rn", {59'd0, ex_rn}, {59'd0, e.rn});
            chk("ex_rm", {59'd0, ex_rm}, {59'd0, e.rm});
            chk("ex_rd1", ex_rd1, e.rd1);
            chk("ex_rd2", ex_rd2, e.rd2);
            chk("ex_byp1", {63'd0, ex_byp1}, {63'd0, e.b1});
            chk("ex_byp2", {63'd0, ex_byp2}, {63'd0, e.b2});
        end
    end

    function automatic logic [4:0] rand_addr();
        int k = $urandom_range(0, 9);
        if (k == 0) return 5'd31;
        if (k < 7) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; in_valid = 1'b0;
        rn_addr = '0; rm_addr = '0; stall = 1'b0; flush = 1'b0;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_ex = '0;

        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Fresh array reads all zero; ex_valid stays low until in_valid
        for (int i = 0; i < 32; i++) cycle(1, 0, 0, 0, (i >= 28), 5'(i), 5'(31 - i), 0, 0);

        // Write X5 then read it next cycle from the array
        cycle(1, 1, 5, 64'h1234, 1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 1, 5, 5, 0, 0);

        // Same-cycle write and read of X7 on both ports
        cycle(1, 1, 7, 64'h1111, 1, 0, 0, 0, 0);
        cycle(1, 1, 7, 64'hDEAD, 1, 7, 7, 0, 0);
        cycle(1, 0, 0, 0, 1, 7, 2, 0, 0);

        // Zero register ignores writes and never bypasses
        cycle(1, 1, 31, 64'hFFFF, 1, 31, 31, 0, 0);
        cycle(1, 0, 0, 0, 1, 31, 5, 0, 0);

        // Latch X3=1, then stall two cycles while X3 is rewritten
        cycle(1, 1, 3, 64'h1, 1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 1, 3, 4, 0, 0);
        cycle(1, 1, 3, 64'h9, 1, 0, 0, 1, 0);
        cycle(1, 0, 0, 0, 1, 0, 0, 1, 0);
        cycle(1, 0, 0, 0, 1, 3, 3, 0, 0);

        // Flush beats stall
        cycle(1, 0, 0, 0, 1, 5, 7, 0, 0);
        cycle(1, 1, 5, 64'h77, 1, 1, 2, 1, 1);

        // Mid-stream reset pulse
        cycle(1, 1, 9, 64'hABCD, 1, 5, 7, 0, 0);
        cycle(0, 1, 9, 64'h5555, 1, 9, 5, 0, 0);
        cycle(1, 0, 0, 0, 1, 9, 5, 0, 0);

        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 2) != 0), rand_addr(), {$urandom, $urandom},
                  1'($urandom_range(0, 1)), rand_addr(), rand_addr(),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 11) == 0));
        end
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_regread_stage.md
# id_regread_stage

Decode-stage register read block for the pipelined 64-bit CPU: a 32-entry register file (X31 reads as zero) with two read ports and one write port. The write port is driven by the MEM/WB stage. It also holds the ID/EX pipeline register that latches the Rn/Rm operands for the execute stage. It resolves the MEM/WB-writes-ID-reads hazard internally by write-through bypass, and reports each bypass so downstream hazard/forwarding logic does not act on it twice.

## Interface
Parameters:
- DATA_W, 64, register and operand width
- ZERO_REG, 31, register index that always reads 0 and ignores writes

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- wr_en  in  1  MEM/WB register write enable
- wr_addr  in  5  MEM/WB destination register (Rd)
- wr_data  in  DATA_W  MEM/WB writeback value
- in_valid  in  1  decode stage holds a valid instruction
- rn_addr  in  5  first source register (Rn)
- rm_addr  in  5  second source register (Rm)
- stall  in  1  hold ID/EX contents (load-use or structural stall)
- flush  in  1  kill ID/EX contents (branch taken)
- ex_valid  out  1  ID/EX holds a valid instruction
- ex_rn, ex_rm  out  5 each  latched source addresses
- ex_rd1, ex_rd2  out  DATA_W each  latched operand values
- ex_byp1, ex_byp2  out  1 each  operand was taken from wr_data rather than the array

## Operation
- Array: 32 x DATA_W registers. On rst_n low, all entries are cleared to 0 asynchronously.
- Write: on a rising edge with wr_en=1 and wr_addr!=ZERO_REG, the block writes wr_data into entry wr_addr. Writes to ZERO_REG are dropped.
- Read: the read value is combinational from the array. Reads of ZERO_REG return 0 regardless of bypass.
- Bypass: if wr_en=1, wr_addr==rn_addr and rn_addr!=ZERO_REG, operand 1 = wr_data and byp1=1. Port 2 uses the same rule with rm_addr. Both ports may bypass in the same cycle, e.g. when Rn==Rm==Rd.
- ID/EX register update priority per rising edge:
  1. flush=1: ex_valid=0, every ex_* field=0.
  2. stall=1: hold all fields, subject to the stall refresh below.
  3. Otherwise: load ex_valid=in_valid, ex_rn/ex_rm, the operand values and the bypass flags.
- Stall refresh: while stalled, if wr_en=1, wr_addr==ex_rn and ex_rn!=ZERO_REG, then ex_rd1<=wr_data and ex_byp1<=1. ex_rm/ex_rd2/ex_byp2 follow the same rule. This keeps held operands from going stale.
- Operand values are latched even when in_valid=0. Consumers must qualify them with ex_valid.

## Timing
- Reset values: ex_valid=0, ex_rn=ex_rm=0, ex_rd1=ex_rd2=0, ex_byp1=ex_byp2=0, all array entries 0.
- Latency: addresses presented in cycle N appear on ex_* after the edge ending cycle N (1 cycle).
- A write in cycle N is visible in the array from cycle N+1. With bypass, it is also visible to a read in cycle N.
- flush and stall asserted together: flush wins.
- rst_n asserted mid-operation clears state immediately with no clock edge. The first capture happens on the first edge after rst_n deasserts.
- No combinational path from stall/flush to any output.

## Configuration
- REGREAD_BYPASS_EN defined: same-cycle write-through bypass and stall refresh behave as described above.
- REGREAD_BYPASS_EN undefined:
  - Reads return the pre-write array contents, and ex_byp1/ex_byp2 are tied 0.
  - Stall refresh is removed.
  - The external hazard unit must stall one cycle on a MEM/WB Rd match.

## Test plan
- Reset, then read all 32 registers with no writes -> every ex_rd1/ex_rd2=0, ex_valid=0 until in_valid is applied.
- Write X5=0x1234 in cycle N, then read Rn=5 in cycle N+1 -> ex_rd1=0x1234, ex_byp1=0.
- Same cycle: wr_addr=7, wr_data=0xDEAD, rn=rm=7 -> ex_rd1=ex_rd2=0xDEAD, both byp=1. With the macro undefined: old X7 value, byp=0.
- Write X31=0xFFFF, then read Rn=31 in the same cycle and the next -> 0 both times, byp=0.
- Latch Rn=3 (value 1), assert stall for 2 cycles while writing X3=9 -> ex_rd1 becomes 9 after the write edge, ex_rn stays 3.
- stall=1 and flush=1 together with valid contents -> ex_valid=0, all fields 0. Pulsing rst_n low mid-stream clears outputs immediately.
